// File: rtl/rom_rd_stream.sv
`default_nettype none
// ============================================================================
// rom_rd_stream : command-driven ROM read sequencer feeding a valid/ready
//                 stream through a 2-entry buffer that hides ROM latency.
// Revision      : 1.0
// ============================================================================
module rom_rd_stream #(
  parameter int DW = 8,
  parameter int MD = 1024,
  parameter int AW = $clog2(MD),
  parameter int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_en,
  input  logic          cmd_vld,
  output logic          cmd_rdy,
  input  logic [AW-1:0] cmd_adr,
  input  logic [LW-1:0] cmd_len,
  output logic          rom_rd,
  output logic [AW-1:0] rom_adr,
  input  logic [DW-1:0] rom_dat_r,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_dat,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [AW-1:0] c_adr_max = AW'(MD - 1);

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_rem;
  logic          r_inflight;
  logic          r_inflight_last;
  logic [DW-1:0] r_dat [2];
  logic          r_lst [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_occ;
  logic          r_busy;
  logic          r_done;

  logic          w_pop;
  logic          w_push;
  logic [2:0]    w_pend;
  logic          w_issue;
  logic          w_rem_one;
  logic [AW-1:0] w_addr_nxt;

  assign w_pop      = out_vld & out_rdy & clk_en;
  assign w_push     = r_inflight;
  // Words buffered plus the one in flight, less the one leaving this cycle.
  assign w_pend     = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue    = (r_state == S_RUN) && (r_rem != '0) && (w_pend < 3'd2);
  assign w_rem_one  = (r_rem == LW'(1));
  assign w_addr_nxt = (r_addr == c_adr_max) ? '0 : r_addr + AW'(1);

  assign rom_rd   = w_issue & clk_en;
  assign rom_adr  = r_addr;
  assign cmd_rdy  = (r_state == S_IDLE);
  assign out_vld  = (r_occ != 2'd0);
  assign out_dat  = r_dat[r_rd_ptr];
  assign out_last = r_lst[r_rd_ptr];
  assign busy     = r_busy;
  assign done     = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_rem           <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_dat[0]        <= '0;
      r_dat[1]        <= '0;
      r_lst[0]        <= 1'b0;
      r_lst[1]        <= 1'b0;
      r_wr_ptr        <= 1'b0;
      r_rd_ptr        <= 1'b0;
      r_occ           <= 2'd0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else if (clk_en) begin
      r_done <= 1'b0;

      if (w_push) begin
        r_dat[r_wr_ptr] <= rom_dat_r;
        r_lst[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase

      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_last <= w_rem_one;
        r_addr          <= w_addr_nxt;
        r_rem           <= r_rem - LW'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (cmd_vld) begin
            if (cmd_len != '0) begin
              r_addr  <= cmd_adr;
              r_rem   <= cmd_len;
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_issue && w_rem_one) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((r_occ == 2'd0) && !r_inflight) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rom_rd_stream.sv
`default_nettype none
// ============================================================================
// tb_rom_rd_stream : directed, table-driven bench for rom_rd_stream.
// Revision         : 1.0
// ============================================================================
module tb_rom_rd_stream;

  localparam int DW = 8;
  localparam int MD = 1024;
  localparam int AW = 10;
  localparam int LW = 11;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          clk_en  = 1'b1;
  logic          cmd_vld = 1'b0;
  logic          out_rdy = 1'b1;
  logic [AW-1:0] cmd_adr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          cmd_rdy, rom_rd, out_vld, out_last, busy, done;
  logic [AW-1:0] rom_adr;
  logic [DW-1:0] rom_dat_r, out_dat;
  logic [DW-1:0] rom_q = '0;

  always #5 clk = ~clk;

  rom_rd_stream #(.DW(DW), .MD(MD), .AW(AW), .LW(LW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .cmd_vld  (cmd_vld),
    .cmd_rdy  (cmd_rdy),
    .cmd_adr  (cmd_adr),
    .cmd_len  (cmd_len),
    .rom_rd   (rom_rd),
    .rom_adr  (rom_adr),
    .rom_dat_r(rom_dat_r),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_dat  (out_dat),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  // ROM model: mem[i] = i, one enabled cycle of read latency.
  assign rom_dat_r = rom_q;
  always @(posedge clk) begin
    if (clk_en && rom_rd) rom_q <= rom_adr[DW-1:0];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor state, sampled on the falling edge.
  int            cyc = 0;
  int            accept_cyc, first_vld_cyc, pop_first_cyc, pop_last_cyc;
  int            done_cnt, viol, rdy_low_cnt, outstanding = 0;
  logic [DW-1:0] got_q [$];
  logic          last_q [$];
  logic [AW-1:0] rd_q [$];
  bit            have_prev = 0;
  logic          prev_en, prev_vld, prev_pop, prev_last;
  logic [DW-1:0] prev_dat;
  logic [AW+DW+5:0] prev_snap;

  always @(negedge clk) begin
    logic pop;
    logic [AW+DW+5:0] snap;
    cyc++;
    if (rst_n) begin
      pop  = out_vld & out_rdy & clk_en;
      snap = {out_vld, out_dat, out_last, busy, done, cmd_rdy, rom_adr};
      if (cmd_vld && cmd_rdy && clk_en) accept_cyc = cyc;
      if (out_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (!cmd_rdy) rdy_low_cnt++;
      if (rom_rd && !clk_en) viol++;
      if (rom_rd && (outstanding - int'(pop)) >= 2) viol++;
      if (rom_rd) rd_q.push_back(rom_adr);
      if (pop) begin
        got_q.push_back(out_dat);
        last_q.push_back(out_last);
        if (pop_first_cyc < 0) pop_first_cyc = cyc;
        pop_last_cyc = cyc;
      end
      if (done && prev_en) begin
        done_cnt++;
        if (busy) viol++;
      end
      if (have_prev && !prev_en && snap !== prev_snap) viol++;
      if (have_prev && prev_vld && !prev_pop &&
          (!out_vld || out_dat !== prev_dat || out_last !== prev_last)) viol++;
      outstanding += int'(rom_rd) - int'(pop);
      if (outstanding > 2 || outstanding < 0) viol++;
      prev_en   = clk_en;
      prev_vld  = out_vld;
      prev_pop  = pop;
      prev_dat  = out_dat;
      prev_last = out_last;
      prev_snap = snap;
      have_prev = 1;
    end else begin
      outstanding = 0;
      have_prev   = 0;
    end
  end

  typedef struct {
    int adr;
    int len;
    bit toggle;
    int freeze_at;
    int exp_first;
    int exp_lastw;
  } vec_t;

  task automatic clear_mon();
    got_q.delete();
    last_q.delete();
    rd_q.delete();
    done_cnt      = 0;
    viol          = 0;
    rdy_low_cnt   = 0;
    accept_cyc    = -1;
    first_vld_cyc = -1;
    pop_first_cyc = -1;
    pop_last_cyc  = -1;
  endtask

  task automatic run_burst(input vec_t v);
    bit finished = 0;
    int nlast    = 0;
    int adr_bad  = 0;
    clear_mon();
    @(posedge clk); #1;
    cmd_adr = AW'(v.adr);
    cmd_len = LW'(v.len);
    cmd_vld = 1'b1;
    out_rdy = 1'b1;
    @(posedge clk); #1;
    cmd_vld = 1'b0;
    check("busy_after_accept", 32'(busy), (v.len != 0) ? 1 : 0);
    for (int c = 0; c < 300; c++) begin
      if (v.toggle) out_rdy = ($urandom_range(0, 1) != 0);
      clk_en = !(v.freeze_at != 0 && c >= v.freeze_at && c < v.freeze_at + 3);
      @(posedge clk); #1;
      if (done_cnt != 0) begin
        finished = 1;
        break;
      end
    end
    clk_en  = 1'b1;
    out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("done_seen", 32'(finished), 1);
    check("done_count", done_cnt, 1);
    check("word_count", got_q.size(), v.len);
    for (int k = 0; k < got_q.size() && k < v.len; k++) begin
      check("data", 32'(got_q[k]), ((v.adr + k) % MD) & 255);
      if (last_q[k]) nlast++;
    end
    check("rd_count", rd_q.size(), v.len);
    for (int k = 0; k < rd_q.size(); k++) begin
      if (int'(rd_q[k]) != (v.adr + k) % MD) adr_bad++;
    end
    check("rd_addr_errors", adr_bad, 0);
    check("protocol_violations", viol, 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_cmd_rdy", 32'(cmd_rdy), 1);
    if (v.len != 0 && got_q.size() == v.len) begin
      check("first_word", 32'(got_q[0]), v.exp_first);
      check("last_word", 32'(got_q[v.len-1]), v.exp_lastw);
      check("last_flag_count", nlast, 1);
      check("last_flag_pos", 32'(last_q[v.len-1]), 1);
      check("first_vld_latency", first_vld_cyc - accept_cyc, 3);
      if (!v.toggle && v.freeze_at == 0)
        check("back_to_back", pop_last_cyc - pop_first_cyc, v.len - 1);
    end
    if (v.len == 0) begin
      check("noop_cmd_rdy_low", rdy_low_cnt, 0);
      check("noop_out_vld", first_vld_cyc, -1);
    end
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{5,    4,  0, 0, 8'h05, 8'h08};
    vecs[1] = '{1022, 4,  0, 0, 8'hFE, 8'h01};
    vecs[2] = '{0,    16, 1, 0, 8'h00, 8'h0F};
    vecs[3] = '{60,   8,  0, 4, 8'h3C, 8'h43};
    vecs[4] = '{7,    0,  0, 0, 0,     0};
    vecs[5] = '{300,  3,  1, 0, 8'h2C, 8'h2E};
    vecs[6] = '{1023, 1,  0, 0, 8'hFF, 8'hFF};

    #2;
    check("rst_cmd_rdy",  32'(cmd_rdy),  1);
    check("rst_rom_rd",   32'(rom_rd),   0);
    check("rst_rom_adr",  32'(rom_adr),  0);
    check("rst_out_vld",  32'(out_vld),  0);
    check("rst_out_dat",  32'(out_dat),  0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_busy",     32'(busy),     0);
    check("rst_done",     32'(done),     0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_burst(vecs[i]);

    // Reset in the middle of an 8-word burst, after the third word is taken.
    begin
      bit got3 = 0;
      clear_mon();
      @(posedge clk); #1;
      cmd_adr = AW'(40);
      cmd_len = LW'(8);
      cmd_vld = 1'b1;
      @(posedge clk); #1;
      cmd_vld = 1'b0;
      for (int c = 0; c < 50; c++) begin
        @(posedge clk); #1;
        if (got_q.size() >= 3) begin
          got3 = 1;
          break;
        end
      end
      check("abort_three_words", 32'(got3), 1);
      check("abort_busy_before", 32'(busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_out_vld", 32'(out_vld), 0);
      check("async_rst_busy",    32'(busy),    0);
      check("async_rst_cmd_rdy", 32'(cmd_rdy), 1);
      check("async_rst_rom_rd",  32'(rom_rd),  0);
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
    run_burst('{20, 2, 0, 0, 8'h14, 8'h15});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
